pipe_in_check_multi: RTL
========================

Name: pipe_in_check_multi

Overview:
Parametrised successor to the single-width pipe-in checker used behind okBTPipeIn endpoints in the pipe throughput test bitfiles. It accepts host-written words of configurable width. It compares each word against one of five selectable reference patterns. It reports a saturating error count, a total word count and the index of the first failing word. A rotating throttle mask drives ep_ready for flow-control testing.

Parameters:
DATA_WIDTH, 32, pipe word width; multiple of 32, range 32..256
ERR_COUNT_WIDTH, 32, width of error_count; saturating
THROTTLE_WIDTH, 32, length of the rotating throttle mask

Ports:
clk  input  1  okClk domain; all logic on rising edge
reset  input  1  synchronous, active-high; clears all state
pipe_in_write  input  1  write strobe from okBTPipeIn ep_write
pipe_in_data  input  DATA_WIDTH  written word
pipe_in_ready  output  1  to okBTPipeIn ep_ready
throttle_set  input  1  load throttle_val into throttle mask
throttle_val  input  THROTTLE_WIDTH  new throttle mask
fixed_pattern  input  DATA_WIDTH  operand for fixed/alternating modes
pattern  input  3  pattern select, sampled only while reset=1
error_count  output  ERR_COUNT_WIDTH  mismatching words, saturating
word_count  output  32  words received, wraps modulo 2^32
first_err_valid  output  1  sticky; a mismatch has occurred
first_err_index  output  32  word_count value of first mismatch

Behaviour:
- Reset values:
  - error_count=0, word_count=0, first_err_valid=0, first_err_index=0.
  - Throttle mask = all ones, so pipe_in_ready=1 from the first cycle after reset.
  - Generator is at its seed. Mode register loads pattern.
- Mode register:
  - Latched every cycle that reset=1; held otherwise.
  - A change to pattern mid-run has no effect until the next reset.
- Patterns; expected word k, counting from 0 after reset:
  - 0 counter: k zero-extended, wraps modulo 2^DATA_WIDTH.
  - 1 LFSR: each 32-bit lane i is an independent Fibonacci LFSR.
    - Step: next = {cur[30:0], cur[31]^cur[21]^cur[1]^cur[0]}.
    - Lane i seed = 32'h0D0C0B0A ^ i.
    - Word 0 is the seed.
  - 2 walking one: word 0 = 1; each subsequent word rotates left by 1, wrapping at DATA_WIDTH.
  - 3 fixed: every word = fixed_pattern.
  - 4 alternating: even k = fixed_pattern, odd k = ~fixed_pattern.
  - 5-7: reserved; behave as mode 0.
- Generator advances exactly once per cycle with pipe_in_write=1, never otherwise.
- Every write is checked, even if pipe_in_ready=0 in that cycle; the host is responsible for honouring ready.
- Latency: a write in cycle N is reflected in the outputs at cycle N+1:
  - word_count increments.
  - On mismatch, error_count increments, stopping at all ones.
  - On mismatch with first_err_valid=0: first_err_index = word_count value before the increment (i.e. k), and first_err_valid is set.
- Throttle:
  - pipe_in_ready = mask[0].
  - Every cycle the mask rotates right by one, regardless of writes.
  - throttle_set=1 loads throttle_val instead of rotating; the new mask[0] appears on ready the following cycle.
  - Mask all zeros holds ready low indefinitely; this is legal.
- reset takes priority over write and throttle_set in the same cycle. A write coincident with reset is discarded.
- Reset mid-transfer: counters and generator return to the seed next cycle; the host must restart the transfer.

Optional Feature:
Macro PIPE_CHECK_ERR_BITS_EN.
- Defined:
  - Adds output err_bits [DATA_WIDTH-1:0], reset 0.
  - Each checked write ORs (pipe_in_data ^ expected) into err_bits, with the same N+1 latency.
  - Identifies stuck or crossed data lanes.
- Undefined:
  - Port and logic are absent.
  - All other behaviour is identical.

Test Plan:
- Counter mode, DATA_WIDTH=32, 16 correct words (0..15) -> word_count=16, error_count=0, first_err_valid=0.
- Counter mode, 10 words with word 5 sent as 0xFFFFFFFF -> error_count=1, first_err_valid=1, first_err_index=5. With PIPE_CHECK_ERR_BITS_EN: err_bits=0xFFFFFFFA.
- LFSR mode, DATA_WIDTH=64:
  - Word 0 = {0x0D0C0B0B, 0x0D0C0B0A} and word 1 = each lane stepped once -> error_count=0.
  - Lanes swapped on word 1 -> error_count=1.
- Walking one, DATA_WIDTH=32, 33 words ending with 0x00000001 at k=32 -> error_count=0. Pattern changed to 3 mid-run without reset -> checking still in walking-one mode.
- throttle_set with 0xAAAAAAAA -> pipe_in_ready sequence 0,1,0,1,... starting the cycle after the load. Same-cycle reset and throttle_set -> mask = all ones.
- ERR_COUNT_WIDTH=4, fixed mode, 20 mismatching words -> error_count=15 (saturated), word_count=20. Then reset mid-run -> all outputs 0 next cycle, ready=1.

Source files
------------

// File: rtl/pipe_in_check_multi.sv
// pipe_in_check_multi: checks host-written pipe words of configurable width
// against a selectable reference pattern and reports saturating error, word
// and first-failure statistics. A rotating throttle mask drives pipe_in_ready.
// Optional build macro PIPE_CHECK_ERR_BITS_EN adds the sticky err_bits output.
module pipe_in_check_multi #(
   parameter int unsigned DATA_WIDTH      = 32,
   parameter int unsigned ERR_COUNT_WIDTH = 32,
   parameter int unsigned THROTTLE_WIDTH  = 32
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       pipe_in_write,
   input  logic [DATA_WIDTH-1:0]      pipe_in_data,
   output logic                       pipe_in_ready,
   input  logic                       throttle_set,
   input  logic [THROTTLE_WIDTH-1:0]  throttle_val,
   input  logic [DATA_WIDTH-1:0]      fixed_pattern,
   input  logic [2:0]                 pattern,
   output logic [ERR_COUNT_WIDTH-1:0] error_count,
   output logic [31:0]                word_count,
   output logic                       first_err_valid,
   output logic [31:0]                first_err_index
`ifdef PIPE_CHECK_ERR_BITS_EN
   ,
   output logic [DATA_WIDTH-1:0]      err_bits
`endif
);

   localparam int unsigned LANES = DATA_WIDTH / 32;

   typedef enum logic [2:0] {
      MODE_COUNT = 3'd0,
      MODE_LFSR  = 3'd1,
      MODE_WALK  = 3'd2,
      MODE_FIXED = 3'd3,
      MODE_ALT   = 3'd4
   } mode_t;

   mode_t                     mode;
   logic [DATA_WIDTH-1:0]     gen;
   logic [DATA_WIDTH-1:0]     gen_seed_c;
   logic [DATA_WIDTH-1:0]     gen_next_c;
   logic [DATA_WIDTH-1:0]     expected_c;
   logic [DATA_WIDTH-1:0]     diff_c;
   logic                      mismatch_c;
   logic [THROTTLE_WIDTH-1:0] mask;

   // Every 32-bit lane starts from its own seed so lanes never alias
   function automatic logic [DATA_WIDTH-1:0] lfsr_seed();
      logic [DATA_WIDTH-1:0] s;
      s = '0;
      for (int unsigned i = 0; i < LANES; i++) begin
         s[i*32 +: 32] = 32'h0D0C0B0A ^ 32'(i);
      end
      return s;
   endfunction

   // One Fibonacci step applied independently to every lane
   function automatic logic [DATA_WIDTH-1:0] lfsr_step(input logic [DATA_WIDTH-1:0] cur);
      logic [DATA_WIDTH-1:0] n;
      logic [31:0]           l;
      n = '0;
      for (int unsigned i = 0; i < LANES; i++) begin
         l              = cur[i*32 +: 32];
         n[i*32 +: 32]  = {l[30:0], l[31] ^ l[21] ^ l[1] ^ l[0]};
      end
      return n;
   endfunction

   // Generator seed follows the pattern input being latched during reset
   always_comb begin
      gen_seed_c = '0;
      case (mode_t'(pattern))
         MODE_LFSR: gen_seed_c = lfsr_seed();
         MODE_WALK: gen_seed_c = DATA_WIDTH'(1);
         default:   gen_seed_c = '0;
      endcase
   end

   // Generator advance for the active mode; reserved modes count
   always_comb begin
      gen_next_c = gen;
      case (mode)
         MODE_LFSR:  gen_next_c = lfsr_step(gen);
         MODE_WALK:  gen_next_c = {gen[DATA_WIDTH-2:0], gen[DATA_WIDTH-1]};
         MODE_FIXED: gen_next_c = gen;
         MODE_ALT:   gen_next_c = gen;
         default:    gen_next_c = gen + DATA_WIDTH'(1);
      endcase
   end

   // Expected word; fixed modes use the live operand, alternating keys on k parity
   always_comb begin
      expected_c = gen;
      case (mode)
         MODE_FIXED: expected_c = fixed_pattern;
         MODE_ALT:   expected_c = word_count[0] ? ~fixed_pattern : fixed_pattern;
         default:    expected_c = gen;
      endcase
      diff_c     = pipe_in_data ^ expected_c;
      mismatch_c = pipe_in_write && (diff_c != '0);
   end

   // Mode latch and generator; mode only reloads while reset is held
   always_ff @(posedge clk) begin
      if (reset) begin
         mode <= mode_t'(pattern);
         gen  <= gen_seed_c;
      end else if (pipe_in_write) begin
         gen  <= gen_next_c;
      end
   end

   // Word and saturating error counters
   always_ff @(posedge clk) begin
      if (reset) begin
         word_count  <= '0;
         error_count <= '0;
      end else begin
         if (pipe_in_write) begin
            word_count <= word_count + 32'd1;
         end
         if (mismatch_c && (error_count != '1)) begin
            error_count <= error_count + ERR_COUNT_WIDTH'(1);
         end
      end
   end

   // Sticky capture of the index of the first failing word
   always_ff @(posedge clk) begin
      if (reset) begin
         first_err_valid <= 1'b0;
         first_err_index <= '0;
      end else if (mismatch_c && !first_err_valid) begin
         first_err_valid <= 1'b1;
         first_err_index <= word_count;
      end
   end

   // Throttle mask: load on throttle_set, otherwise rotate right each cycle
   always_ff @(posedge clk) begin
      if (reset) begin
         mask <= '1;
      end else if (throttle_set) begin
         mask <= throttle_val;
      end else begin
         mask <= (mask >> 1) | (mask << (THROTTLE_WIDTH - 1));
      end
   end

   assign pipe_in_ready = mask[0];

`ifdef PIPE_CHECK_ERR_BITS_EN
   // Accumulate every differing bit position seen since reset
   always_ff @(posedge clk) begin
      if (reset) begin
         err_bits <= '0;
      end else if (pipe_in_write) begin
         err_bits <= err_bits | diff_c;
      end
   end
`endif

endmodule
